// File: rtl/sobel_window_gen.sv
// sobel_window_gen
//   Streaming 3x3 window generator feeding a Sobel gradient stage. Takes a
//   raster-order pixel stream, keeps the two previous image lines in line
//   buffers and emits every complete 3x3 neighbourhood with its centre (i,j).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_pix valid
//   in_ready   out  block accepts in_pix this cycle
//   in_pix     in   pixel, raster order starting at (0,0)
//   out_valid  out  win/out_row/out_col valid
//   out_ready  in   downstream accepts the window
//   win        out  win[k*PIX_W +: PIX_W] = Pk, P0 top-left .. P8 bottom-right
//   out_row    out  centre row (1..IMG_H-2)
//   out_col    out  centre column (1..IMG_W-2)
//   frame_done out  one-cycle pulse after the last pixel of a frame is accepted
//   stall_cnt  out  saturating count of out_valid && !out_ready cycles
//                   (present only when SOBEL_WIN_STALL_CNT_EN is defined)
//
// Optional feature macro: SOBEL_WIN_STALL_CNT_EN

module sobel_window_gen #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] win,
  output logic [5:0]         out_row,
  output logic [5:0]         out_col,
  output logic               frame_done
`ifdef SOBEL_WIN_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e             r_state;
  logic [5:0]         r_col;
  logic [5:0]         r_row;
  logic               r_frame_done;

  // Line buffer 0 holds row r-2, line buffer 1 holds row r-1 at the current column.
  logic [PIX_W-1:0]   r_lb0 [IMG_W];
  logic [PIX_W-1:0]   r_lb1 [IMG_W];

  // Per window row: *0 is column c-2, *1 is column c-1.
  logic [PIX_W-1:0]   r_t0, r_t1, r_m0, r_m1, r_b0, r_b1;

  logic               r_out_valid;
  logic [9*PIX_W-1:0] r_win;
  logic [5:0]         r_out_row;
  logic [5:0]         r_out_col;

  logic               w_accept;
  logic               w_emit;
  logic               w_col_last;
  logic               w_row_last;
  logic [PIX_W-1:0]   w_top;
  logic [PIX_W-1:0]   w_mid;
  logic [9*PIX_W-1:0] w_win;

  // One-deep output register: accept whenever the slot is free or being drained.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_col_last = (r_col == 6'(IMG_W - 1));
  assign w_row_last = (r_row == 6'(IMG_H - 1));
  assign w_top      = r_lb0[r_col];
  assign w_mid      = r_lb1[r_col];
  // c>=2 keeps windows from straddling a row boundary.
  assign w_emit     = w_accept && (r_row >= 6'd2) && (r_col >= 6'd2);
  assign w_win      = {in_pix, r_b1, r_b0, w_mid, r_m1, r_m0, w_top, r_t1, r_t0};

  // Frame sequencing: position counters, state and end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_col <= w_col_last ? 6'd0 : r_col + 6'd1;
        if (w_col_last) begin
          r_row <= w_row_last ? 6'd0 : r_row + 6'd1;
        end
        unique case (r_state)
          StIdle: r_state <= StFill;
          StFill: begin
            if (r_row == 6'd2 && r_col == 6'd0) begin
              r_state <= StRun;
            end
          end
          StRun: begin
            if (w_row_last && w_col_last) begin
              r_state      <= StIdle;
              r_frame_done <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Line buffers and window shift registers carry no reset; every value is
  // rewritten before it contributes to an emitted window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= w_mid;
      r_lb1[r_col] <= in_pix;
      r_t0         <= r_t1;
      r_t1         <= w_top;
      r_m0         <= r_m1;
      r_m1         <= w_mid;
      r_b0         <= r_b1;
      r_b1         <= in_pix;
    end
  end

  // Output register: a new window may replace one consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_win       <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_win       <= w_win;
      r_out_row   <= r_row - 6'd1;
      r_out_col   <= r_col - 6'd1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign win        = r_win;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

`ifdef SOBEL_WIN_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: the driver pushes the expected window
// (built from the known pixel pattern) on every accept that should emit one;
// a negedge monitor pops and compares on each out_valid && out_ready.

module tb_sobel_window_gen;

  localparam int W = 64;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pix;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] win;
  logic [5:0]  out_row;
  logic [5:0]  out_col;
  logic        frame_done;
`ifdef SOBEL_WIN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  sobel_window_gen #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win       (win),
    .out_row   (out_row),
    .out_col   (out_col),
    .frame_done(frame_done)
`ifdef SOBEL_WIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [71:0] win;
    logic [5:0]  row;
    logic [5:0]  col;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_win  = 0;
  int   n_done = 0;

  function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] base);
    logic [7:0] v;
    v = 8'(r * 64 + c);
    return v + base;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_ready) check("in_ready_free", 72'(in_ready), 72'(1));
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window: got row %0d col %0d expected none", out_row,
                     out_col);
          end else begin
            e = q[0];
            check(out_ready ? "window" : "held_window", win, e.win);
            check("out_row", 72'(out_row), 72'(e.row));
            check("out_col", 72'(out_col), 72'(e.col));
            if (!out_ready) check("in_ready_stall", 72'(in_ready), 72'(0));
            if (out_ready) begin
              void'(q.pop_front());
              n_win++;
            end
          end
        end
        if (frame_done) n_done++;
      end
    end
  end

  // Present one pixel and wait (bounded) for it to be accepted.
  task automatic send_pix(input int r, input int c, input logic [7:0] base);
    bit   acc;
    exp_t e;
    in_valid = 1'b1;
    in_pix   = pix(r, c, base);
    acc      = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted in 100 cycles", r, c);
      finish_now();
    end
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) begin
        e.win[k*8 +: 8] = pix(r - 2 + k / 3, c - 2 + k % 3, base);
      end
      e.row = 6'(r - 1);
      e.col = 6'(c - 1);
      q.push_back(e);
    end
    if (r == H - 1 && c == W - 1) check("frame_done_pulse", 72'(frame_done), 72'(1));
  endtask

  // One frame; optional 5-cycle output stall before pixel stall_idx, optional
  // early stop after stop_after accepts.
  task automatic send_frame(input logic [7:0] base, input int stall_idx, input int stop_after);
    int r;
    int c;
    for (int idx = 0; idx < W * H; idx++) begin
      r = idx / W;
      c = idx % W;
      if (idx == stop_after) begin
        in_valid = 1'b0;
        return;
      end
      if (idx == stall_idx) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pix    = pix(r, c, base);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      send_pix(r, c, base);
      if (idx == 129) check("no_window_before_131", 72'(out_valid), 72'(0));
      if (idx == 130) begin
        check("first_valid", 72'(out_valid), 72'(1));
        check("first_row", 72'(out_row), 72'(1));
        check("first_col", 72'(out_col), 72'(1));
      end
      if (r == 5 && c == 1) check("row_edge_no_valid", 72'(out_valid), 72'(0));
      if (r == 5 && c == 2) begin
        check("row_edge_valid", 72'(out_valid), 72'(1));
        check("row_edge_row", 72'(out_row), 72'(4));
        check("row_edge_col", 72'(out_col), 72'(1));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 72'(q.size()), 72'(0));
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_now();
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pix    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_win", win, 72'(0));
    check("rst_out_row", 72'(out_row), 72'(0));
    check("rst_out_col", 72'(out_col), 72'(0));
    check("rst_frame_done", 72'(frame_done), 72'(0));
    rst = 1'b0;
    #1;
    check("rst_in_ready", 72'(in_ready), 72'(1));

    // Ramp frame followed back-to-back by ramp+0x80 frame.
    n_win  = 0;
    n_done = 0;
    send_frame(8'h00, -1, -1);
    send_frame(8'h80, -1, -1);
    drain();
    check("two_frame_windows", 72'(n_win), 72'(2 * 3844));
    check("two_frame_done", 72'(n_done), 72'(2));

    // Ramp frame with a 5-cycle downstream stall.
    n_win  = 0;
    n_done = 0;
    send_frame(8'h00, 660, -1);
    drain();
    check("stall_frame_windows", 72'(n_win), 72'(3844));
    check("stall_frame_done", 72'(n_done), 72'(1));
`ifdef SOBEL_WIN_STALL_CNT_EN
    check("stall_cnt_5", 72'(stall_cnt), 72'(5));
`endif

    // Reset in the middle of a frame, then a full restart.
    send_frame(8'h00, -1, 1000);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 72'(out_valid), 72'(0));
    check("midrst_out_row", 72'(out_row), 72'(0));
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    n_win  = 0;
    n_done = 0;
    send_frame(8'h00, -1, -1);
    drain();
    check("restart_windows", 72'(n_win), 72'(3844));
    check("restart_done", 72'(n_done), 72'(1));

`ifdef SOBEL_WIN_STALL_CNT_EN
    // Long stall to reach saturation.
    send_frame(8'h00, -1, 131);
    out_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("stall_cnt_sat", 72'(stall_cnt), 72'(16'hFFFF));
    out_ready = 1'b1;
    drain();
`endif

    finish_now();
  end

endmodule
